cond_exec_stage: RTL and testbench
==================================

// Module: cond_exec_stage
// PURPOSE
//   Execute-stage conditional-execution unit of the pipelined ARM core.
//   - Holds the architectural NZCV flag register.
//   - Evaluates the instruction's condition field against the current flags.
//   - Gates the instruction's control writes and conditionally updates the flags.
//   - Registers the gated controls into the Memory stage.
// PARAMETERS
//   FLAG_RST  4'b0000  NZCV value loaded on reset
//   CNT_W     16       width of squash counter (used only with COND_SQUASH_CNT_EN)
// PORTS
//   clk         in   1      clock; all state updates on rising edge
//   reset       in   1      asynchronous, active-high reset
//   Stall       in   1      hold E->M register and flags
//   Flush       in   1      load bubble into E->M register
//   ValidE      in   1      E-stage slot holds a real instruction
//   CondE       in   4      instruction condition field (ARM encoding)
//   FlagWriteE  in   2      [1] = write N,Z; [0] = write C,V
//   ALUFlags    in   4      {N,Z,C,V} from the E-stage ALU
//   PCSrcE      in   1      instruction writes PC
//   RegWriteE   in   1      instruction writes a register
//   MemWriteE   in   1      instruction writes memory
//   BranchE     in   1      instruction is a branch
//   Flags       out  4      current architectural {N,Z,C,V}
//   CondExE     out  1      combinational: condition passes
//   BranchTakenE out 1      combinational: BranchE & CondExE & ValidE
//   PCSrcM      out  1      registered, gated PCSrcE
//   RegWriteM   out  1      registered, gated RegWriteE
//   MemWriteM   out  1      registered, gated MemWriteE
//   SquashCnt   out  CNT_W  squashed-instruction count; port exists only with macro
// BEHAVIOUR
//   Reset (async, any cycle, including mid-stall)
//     - Flags <= FLAG_RST.
//     - PCSrcM, RegWriteM, MemWriteM <= 0.
//     - SquashCnt <= 0.
//   Condition evaluation
//     - CondExE uses the registered Flags only. There is no same-cycle bypass
//       from ALUFlags.
//     - Codes 0000-1101: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE, with GE = (N==V).
//     - 1110 (AL) -> 1.
//     - 1111 -> 0: undefined code, instruction treated as not executed.
//   Let Exec = ValidE & CondExE.
//   Flag update, on rising edge when ~Stall & Exec
//     - FlagWriteE[1]: Flags[3:2] <= ALUFlags[3:2].
//     - FlagWriteE[0]: Flags[1:0] <= ALUFlags[1:0].
//     - Bits not selected hold their value.
//     - Latency: the next instruction in E sees the new flags (1 cycle).
//     - Flush does not block a flag update in the same cycle; only Stall does.
//   E->M register, priority reset > Flush > Stall > load
//     - Flush: all M outputs <= 0 (Flush + Stall together -> bubble).
//     - Stall: hold all M outputs.
//     - Load: XM <= XE & Exec, for X in {PCSrc, RegWrite, MemWrite}.
//   ValidE=0: no flag write, M controls loaded as 0, never counted as squash.
// CONFIGURATION
//   COND_SQUASH_CNT_EN defined
//     - SquashCnt port present.
//     - Increments on an edge with ~Stall & ValidE & ~CondExE.
//     - Saturates at all-ones (no wrap).
//     - Flush in the same cycle does not suppress the increment.
//   COND_SQUASH_CNT_EN undefined
//     - Port and counter absent.
//     - All other behaviour identical.
// TESTING
//   1 Reset mid-operation: Flags=1111 and RegWriteM=1; assert reset between
//     edges -> Flags=0000 and RegWriteM=0 immediately.
//   2 Flag update then branch: CondE=1110, FlagWriteE=11, ALUFlags=0100 ->
//     Flags=0100 next cycle. Then CondE=0000, BranchE=1 -> CondExE=1,
//     BranchTakenE=1.
//   3 Partial write: Flags=1111, FlagWriteE=10, ALUFlags=0000, AL ->
//     Flags=0011.
//   4 Squash: Flags=0000, CondE=0000, FlagWriteE=11, ALUFlags=1111,
//     RegWriteE=1 -> Flags stay 0000, RegWriteM=0, SquashCnt +1.
//   5 Stall=Flush=1 with Exec and MemWriteE=1, FlagWriteE=11 ->
//     MemWriteM=0, Flags unchanged.
//     Stall alone -> M outputs hold the previous values.
//   6 CondE=1111 -> CondExE=0.
//     With CNT_W=2: 5 consecutive squashes -> SquashCnt=3 (saturated).

Source files
------------

// File: rtl/cond_exec_stage.sv
// Execute-stage conditional-execution unit: NZCV flag register, condition check,
// control gating and the E->M control register. Optional squash counter: COND_SQUASH_CNT_EN.
module cond_exec_stage #(
  parameter logic [3:0] FLAG_RST = 4'b0000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Stall,
  input  logic       Flush,
  input  logic       ValidE,
  input  logic [3:0] CondE,
  input  logic [1:0] FlagWriteE,
  input  logic [3:0] ALUFlags,
  input  logic       PCSrcE,
  input  logic       RegWriteE,
  input  logic       MemWriteE,
  input  logic       BranchE,
  output logic [3:0] Flags,
  output logic       CondExE,
  output logic       BranchTakenE,
  output logic       PCSrcM,
  output logic       RegWriteM,
  output logic       MemWriteM
`ifdef COND_SQUASH_CNT_EN
  ,
  output logic [CNT_W-1:0] SquashCnt
`endif
);

  typedef enum logic [3:0] {
    C_EQ = 4'b0000, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
    C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
  } cond_e;

  logic [3:0] r_flags;
  logic       r_pcsrc_m;
  logic       r_regwrite_m;
  logic       r_memwrite_m;

  cond_e      w_cond;
  logic       w_n, w_z, w_c, w_v;
  logic       w_pass;
  logic       w_exec;

  assign w_cond = cond_e'(CondE);
  assign {w_n, w_z, w_c, w_v} = r_flags;

  // Condition is judged on the registered flags only; no bypass from ALUFlags.
  always_comb begin
    w_pass = 1'b0;
    case (w_cond)
      C_EQ: w_pass = w_z;
      C_NE: w_pass = ~w_z;
      C_CS: w_pass = w_c;
      C_CC: w_pass = ~w_c;
      C_MI: w_pass = w_n;
      C_PL: w_pass = ~w_n;
      C_VS: w_pass = w_v;
      C_VC: w_pass = ~w_v;
      C_HI: w_pass = w_c & ~w_z;
      C_LS: w_pass = ~w_c | w_z;
      C_GE: w_pass = (w_n == w_v);
      C_LT: w_pass = (w_n != w_v);
      C_GT: w_pass = ~w_z & (w_n == w_v);
      C_LE: w_pass = w_z | (w_n != w_v);
      C_AL: w_pass = 1'b1;
      C_NV: w_pass = 1'b0;
      default: w_pass = 1'b0;
    endcase
  end

  assign w_exec       = ValidE & w_pass;
  assign CondExE      = w_pass;
  assign BranchTakenE = BranchE & w_pass & ValidE;

  // Flush does not block a flag update; only Stall does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= FLAG_RST;
    end else if (~Stall & w_exec) begin
      if (FlagWriteE[1]) r_flags[3:2] <= ALUFlags[3:2];
      if (FlagWriteE[0]) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcsrc_m    <= 1'b0;
      r_regwrite_m <= 1'b0;
      r_memwrite_m <= 1'b0;
    end else if (Flush) begin
      r_pcsrc_m    <= 1'b0;
      r_regwrite_m <= 1'b0;
      r_memwrite_m <= 1'b0;
    end else if (~Stall) begin
      r_pcsrc_m    <= PCSrcE    & w_exec;
      r_regwrite_m <= RegWriteE & w_exec;
      r_memwrite_m <= MemWriteE & w_exec;
    end
  end

  assign Flags     = r_flags;
  assign PCSrcM    = r_pcsrc_m;
  assign RegWriteM = r_regwrite_m;
  assign MemWriteM = r_memwrite_m;

`ifdef COND_SQUASH_CNT_EN
  logic [CNT_W-1:0] r_squash_cnt;

  // Saturating count of valid instructions that failed their condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_squash_cnt <= '0;
    end else if (~Stall & ValidE & ~w_pass & (r_squash_cnt != '1)) begin
      r_squash_cnt <= r_squash_cnt + CNT_W'(1);
    end
  end

  assign SquashCnt = r_squash_cnt;
`endif

endmodule

// File: tb/tb_cond_exec_stage.sv
// Self-checking bench for cond_exec_stage: directed vector table, reset and
// saturation sequences, then randomized stimulus against a reference model.
module tb_cond_exec_stage;

  localparam int CNT_W = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       Stall, Flush, ValidE;
  logic [3:0] CondE;
  logic [1:0] FlagWriteE;
  logic [3:0] ALUFlags;
  logic       PCSrcE, RegWriteE, MemWriteE, BranchE;
  logic [3:0] Flags;
  logic       CondExE, BranchTakenE, PCSrcM, RegWriteM, MemWriteM;
`ifdef COND_SQUASH_CNT_EN
  logic [CNT_W-1:0] SquashCnt;
`endif

  cond_exec_stage #(.FLAG_RST(4'b0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .ValidE(ValidE),
    .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .Flags(Flags), .CondExE(CondExE), .BranchTakenE(BranchTakenE),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM)
`ifdef COND_SQUASH_CNT_EN
    , .SquashCnt(SquashCnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model state
  logic [3:0] m_flags;
  logic       m_pc, m_rw, m_mw;
  int         m_cnt;

  // ARM conditions as (base predicate selected by cond[3:1]) xor cond[0]; 111x is AL/never.
  function automatic logic cond_pass(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cf, v, p;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: p = z;
      3'd1: p = cf;
      3'd2: p = n;
      3'd3: p = v;
      3'd4: p = cf && !z;
      3'd5: p = (n == v);
      3'd6: p = !z && (n == v);
      default: return !c[0];
    endcase
    return p ^ c[0];
  endfunction

  function automatic logic m_condex();
    return cond_pass(m_flags, CondE);
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000;
    m_pc = 0; m_rw = 0; m_mw = 0;
    m_cnt = 0;
  endtask

  // Called just after a rising edge, with inputs still as they were at the edge.
  task automatic model_clock(input logic [3:0] pre_flags);
    logic pass, ex;
    pass = cond_pass(pre_flags, CondE);
    ex   = ValidE && pass;
    if (!Stall && ex) begin
      if (FlagWriteE[1]) m_flags[3:2] = ALUFlags[3:2];
      if (FlagWriteE[0]) m_flags[1:0] = ALUFlags[1:0];
    end
    if (Flush) begin
      m_pc = 0; m_rw = 0; m_mw = 0;
    end else if (!Stall) begin
      m_pc = PCSrcE && ex; m_rw = RegWriteE && ex; m_mw = MemWriteE && ex;
    end
    if (!Stall && ValidE && !pass && m_cnt < (1 << CNT_W) - 1) m_cnt++;
  endtask

  task automatic drive(input logic st, input logic fl, input logic va, input logic [3:0] c,
                       input logic [1:0] fw, input logic [3:0] alu,
                       input logic pc, input logic rw, input logic mw, input logic br);
    Stall = st; Flush = fl; ValidE = va; CondE = c; FlagWriteE = fw; ALUFlags = alu;
    PCSrcE = pc; RegWriteE = rw; MemWriteE = mw; BranchE = br;
  endtask

  task automatic tick();
    logic [3:0] pre;
    pre = m_flags;
    @(posedge clk);
    model_clock(pre);
    #1;
  endtask

  typedef struct {
    logic st, fl, va; logic [3:0] c; logic [1:0] fw; logic [3:0] alu;
    logic pc, rw, mw, br;
    logic e_cx, e_bt; logic [3:0] e_fl; logic e_pc, e_rw, e_mw; int e_cnt;
  } vec_t;

  vec_t vt[13];

  initial begin
    //           st fl va cond     fw     alu      pc rw mw br   cx bt flags    pM rM mM cnt
    vt[0]  = '{0, 0, 1, 4'b1110, 2'b11, 4'b0100, 0, 1, 0, 0,   1, 0, 4'b0100, 0, 1, 0, 0};
    vt[1]  = '{0, 0, 1, 4'b0000, 2'b00, 4'b0000, 1, 0, 0, 1,   1, 1, 4'b0100, 1, 0, 0, 0};
    vt[2]  = '{0, 0, 1, 4'b1110, 2'b11, 4'b1111, 0, 0, 0, 0,   1, 0, 4'b1111, 0, 0, 0, 0};
    vt[3]  = '{0, 0, 1, 4'b1110, 2'b10, 4'b0000, 0, 1, 0, 0,   1, 0, 4'b0011, 0, 1, 0, 0};
    vt[4]  = '{0, 0, 1, 4'b1110, 2'b11, 4'b0000, 0, 0, 1, 0,   1, 0, 4'b0000, 0, 0, 1, 0};
    vt[5]  = '{0, 0, 1, 4'b0000, 2'b11, 4'b1111, 0, 1, 0, 0,   0, 0, 4'b0000, 0, 0, 0, 1};
    vt[6]  = '{1, 1, 1, 4'b1110, 2'b11, 4'b1010, 0, 0, 1, 0,   1, 0, 4'b0000, 0, 0, 0, 1};
    vt[7]  = '{0, 0, 1, 4'b1110, 2'b00, 4'b0000, 1, 1, 1, 0,   1, 0, 4'b0000, 1, 1, 1, 1};
    vt[8]  = '{1, 0, 1, 4'b1110, 2'b11, 4'b1111, 0, 0, 0, 0,   1, 0, 4'b0000, 1, 1, 1, 1};
    vt[9]  = '{0, 1, 1, 4'b1110, 2'b11, 4'b1000, 0, 1, 0, 0,   1, 0, 4'b1000, 0, 0, 0, 1};
    vt[10] = '{0, 0, 1, 4'b1111, 2'b11, 4'b0000, 0, 1, 0, 1,   0, 0, 4'b1000, 0, 0, 0, 2};
    vt[11] = '{0, 0, 0, 4'b1110, 2'b11, 4'b0110, 0, 1, 0, 1,   1, 0, 4'b1000, 0, 0, 0, 2};
    vt[12] = '{0, 0, 1, 4'b1011, 2'b00, 4'b0000, 0, 0, 0, 1,   1, 1, 4'b1000, 0, 0, 0, 2};

    drive(0, 0, 0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_flags", 32'(Flags), 32'h0);
    check("reset_m", 32'({PCSrcM, RegWriteM, MemWriteM}), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].st, vt[i].fl, vt[i].va, vt[i].c, vt[i].fw, vt[i].alu,
            vt[i].pc, vt[i].rw, vt[i].mw, vt[i].br);
      #1;
      check($sformatf("vec%0d_condex", i), 32'(CondExE), 32'(vt[i].e_cx));
      check($sformatf("vec%0d_btaken", i), 32'(BranchTakenE), 32'(vt[i].e_bt));
      tick();
      check($sformatf("vec%0d_flags", i), 32'(Flags), 32'(vt[i].e_fl));
      check($sformatf("vec%0d_mctl", i), 32'({PCSrcM, RegWriteM, MemWriteM}),
            32'({vt[i].e_pc, vt[i].e_rw, vt[i].e_mw}));
`ifdef COND_SQUASH_CNT_EN
      check($sformatf("vec%0d_squash", i), 32'(SquashCnt), 32'(vt[i].e_cnt));
`endif
      @(negedge clk);
    end

    // Asynchronous reset between edges while flags and RegWriteM are set
    drive(0, 0, 1, 4'b1110, 2'b11, 4'b1111, 0, 1, 0, 0);
    tick();
    check("prerst_flags", 32'(Flags), 32'hF);
    check("prerst_rwm", 32'(RegWriteM), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("midrst_flags", 32'(Flags), 32'h0);
    check("midrst_rwm", 32'(RegWriteM), 32'h0);
    model_reset();
    drive(0, 0, 0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Undefined condition never executes; five squashes saturate a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 4'b1111, 2'b11, 4'b1111, 1, 1, 1, 1);
      #1;
      check("nv_condex", 32'(CondExE), 32'h0);
      tick();
      @(negedge clk);
    end
    check("nv_flags", 32'(Flags), 32'h0);
`ifdef COND_SQUASH_CNT_EN
    check("squash_sat", 32'(SquashCnt), 32'h3);
`endif

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
            4'($urandom), 2'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      check("rnd_condex", 32'(CondExE), 32'(m_condex()));
      check("rnd_btaken", 32'(BranchTakenE), 32'(BranchE && ValidE && m_condex()));
      tick();
      check("rnd_flags", 32'(Flags), 32'(m_flags));
      check("rnd_mctl", 32'({PCSrcM, RegWriteM, MemWriteM}), 32'({m_pc, m_rw, m_mw}));
`ifdef COND_SQUASH_CNT_EN
      check("rnd_squash", 32'(SquashCnt), 32'(m_cnt));
`endif
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
